fifo_wr_packer: RTL
===================

Name: fifo_wr_packer

Overview:
- Write-side front end of the dual-clock FIFO, entirely in the wr_clk domain.
- Accepts an 8-bit byte stream with valid/ready/last and packs byte pairs into 16-bit words. First byte goes to [15:8].
- Pads odd-length packets and optionally appends a trailer word. Drives the FIFO write port and honours its registered full flag.

Parameters:
- PAD_BYTE, 8'h00, low byte used to complete the final word of an odd-length packet.
- TRAILER_EN, 1, 1 = append trailer word {TRAILER_TAG, pkt_len[7:0]} after each packet; 0 = no trailer.
- TRAILER_TAG, 8'hA5, upper byte of trailer word.
- CNT_WIDTH, 16, width of the packet statistics counter.

Ports:
- wr_clk  in  1  write-domain clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_data  in  8  input byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  s_data is the final byte of a packet; qualified by s_valid.
- s_ready  out  1  block accepts byte this cycle. Transfer occurs when s_valid & s_ready.
- fifo_wr_en  out  1  write strobe to FIFO.
- fifo_din  out  16  write data to FIFO.
- fifo_full  in  1  FIFO full flag, registered in FIFO, one cycle stale.
- pkt_cnt  out  CNT_WIDTH  number of packets fully written to FIFO; wraps.
- busy  out  1  high when a packet is partly accepted or a write is pending.

Behaviour:
- Reset: asynchronous on rst_n low.
  - state=S_LO; s_ready=0 while rst_n low; fifo_wr_en=0; fifo_din=0; pkt_cnt=0; busy=0.
  - Clears word register, last flag, pkt_len (8 bit) and gap flag.
  - Reset mid-packet discards any partial word or pending write; nothing is written.
- States:
  - S_LO: waiting for the high byte.
  - S_HI: waiting for the low byte.
  - S_WR: data word pending.
  - S_TRL: trailer word pending.
- s_ready = (state==S_LO or S_HI). Combinational from state only, never from s_valid.
- S_LO on transfer:
  - word[15:8]=s_data; pkt_len+=1.
  - If s_last: word[7:0]=PAD_BYTE, last_q=1, go S_WR.
  - Else go S_HI.
- S_HI on transfer: word[7:0]=s_data; pkt_len+=1; last_q=s_last; go S_WR.
- fifo_wr_en = (state==S_WR or S_TRL) & !fifo_full & !gap_q. Combinational.
  - gap_q is fifo_wr_en registered.
  - wr_en is never high in two consecutive cycles. This covers the one-cycle latency of fifo_full, so the FIFO is never written while full.
- fifo_din:
  - S_WR: word.
  - S_TRL: {TRAILER_TAG, pkt_len}. pkt_len is the byte count mod 256 and excludes the pad byte.
  - Otherwise holds its last value; don't-care when fifo_wr_en=0.
- S_WR when fifo_wr_en:
  - If !last_q: go S_LO.
  - If last_q & TRAILER_EN: go S_TRL.
  - If last_q & !TRAILER_EN: pkt_cnt+=1, pkt_len=0, last_q=0, go S_LO.
- S_TRL when fifo_wr_en: pkt_cnt+=1, pkt_len=0, last_q=0, go S_LO.
- S_WR/S_TRL with fifo_full=1 or gap_q=1: hold state and data indefinitely; s_ready=0.
- Throughput, best case with no backpressure:
  - 2 bytes per 3 cycles.
  - The trailer adds at least 2 cycles because of the gap rule.
- busy = (state!=S_LO) | (pkt_len!=0).
- pkt_cnt wraps from all-ones to 0.
- pkt_len wraps at 256 without error.
- s_last with s_valid=0 is ignored.

Test Plan:
- Bytes 11,22,33,44 (last on 44), TRAILER_EN=1, fifo_full=0 -> FIFO writes 1122, 3344, A504. Writes are never on adjacent cycles. pkt_cnt=1. busy=0 after trailer.
- Bytes AA,BB,CC (last on CC), PAD_BYTE=00 -> writes AABB, CC00, A503. pkt_cnt increments once.
- Single byte 7E with last, TRAILER_EN=0 -> single write 7E00. pkt_cnt=1. State back to S_LO.
- fifo_full=1 while in S_WR with word 1234 -> fifo_wr_en=0 and s_ready=0 held 10 cycles. Deassert full -> exactly one write of 1234 on the first cycle fifo_full=0.
- Attached to dfifo, 1024-deep, rd_en=0, stream 2100 bytes -> exactly 1024 words written. FIFO never overruns. s_ready stays 0 once full. Draining resumes writes with no lost or duplicated words.
- rst_n pulsed low in S_HI after byte 55 -> all outputs at reset values immediately. No write of a partial 55xx. Next packet 01,02(last) -> writes 0102, A502.

Source files
------------

// File: rtl/fifo_wr_packer_if.sv
// Byte-stream input and FIFO write-port signals of the write-side packer.
// master is the packer's view; slave is the source/FIFO side.
interface fifo_wr_packer_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        fifo_wr_en;
    logic [15:0] fifo_din;
    logic        fifo_full;

    modport master (
        input  s_data, s_valid, s_last, fifo_full,
        output s_ready, fifo_wr_en, fifo_din
    );

    modport slave (
        output s_data, s_valid, s_last, fifo_full,
        input  s_ready, fifo_wr_en, fifo_din
    );
endinterface

// File: rtl/fifo_wr_packer.sv
// Packs an 8-bit byte stream into 16-bit FIFO words, pads odd packets and
// optionally appends a {tag, length} trailer word after every packet.
//
//   state | meaning
//   S_LO  | waiting for the high byte of a word
//   S_HI  | waiting for the low byte of a word
//   S_WR  | data word pending for the FIFO
//   S_TRL | trailer word pending for the FIFO
module fifo_wr_packer #(
    parameter logic [7:0] PAD_BYTE    = 8'h00,
    parameter bit         TRAILER_EN  = 1'b1,
    parameter logic [7:0] TRAILER_TAG = 8'hA5,
    parameter int         CNT_WIDTH   = 16
) (
    input  logic                 wr_clk,
    input  logic                 rst_n,
    fifo_wr_packer_if.master     bus,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic                 busy
);

    typedef enum logic [1:0] {S_LO, S_HI, S_WR, S_TRL} state_t;

    state_t               state_q, state_d;
    logic [15:0]          word_q, word_d;
    logic [15:0]          din_q;
    logic                 last_q, last_d;
    logic [7:0]           len_q, len_d;
    logic                 gap_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 xfer;

    assign bus.s_ready    = rst_n & ((state_q == S_LO) | (state_q == S_HI));
    assign xfer           = bus.s_valid & bus.s_ready;
    // gap_q forbids back-to-back writes, absorbing the stale full flag
    assign bus.fifo_wr_en = ((state_q == S_WR) | (state_q == S_TRL)) & ~bus.fifo_full & ~gap_q;
    assign busy           = (state_q != S_LO) | (len_q != 8'd0);

    always_comb begin
        bus.fifo_din = din_q;
        case (state_q)
            S_WR:    bus.fifo_din = word_q;
            S_TRL:   bus.fifo_din = {TRAILER_TAG, len_q};
            default: bus.fifo_din = din_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        len_d   = len_q;
        cnt_d   = pkt_cnt;
        case (state_q)
            S_LO: begin
                if (xfer) begin
                    word_d[15:8] = bus.s_data;
                    len_d        = len_q + 8'd1;
                    if (bus.s_last) begin
                        word_d[7:0] = PAD_BYTE;
                        last_d      = 1'b1;
                        state_d     = S_WR;
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (xfer) begin
                    word_d[7:0] = bus.s_data;
                    len_d       = len_q + 8'd1;
                    last_d      = bus.s_last;
                    state_d     = S_WR;
                end
            end
            S_WR: begin
                if (bus.fifo_wr_en) begin
                    if (!last_q) begin
                        state_d = S_LO;
                    end else if (TRAILER_EN) begin
                        state_d = S_TRL;
                    end else begin
                        cnt_d   = pkt_cnt + CNT_WIDTH'(1);
                        len_d   = 8'd0;
                        last_d  = 1'b0;
                        state_d = S_LO;
                    end
                end
            end
            S_TRL: begin
                if (bus.fifo_wr_en) begin
                    cnt_d   = pkt_cnt + CNT_WIDTH'(1);
                    len_d   = 8'd0;
                    last_d  = 1'b0;
                    state_d = S_LO;
                end
            end
            default: state_d = S_LO;
        endcase
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LO;
            word_q  <= 16'd0;
            din_q   <= 16'd0;
            last_q  <= 1'b0;
            len_q   <= 8'd0;
            gap_q   <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            din_q   <= bus.fifo_din;
            last_q  <= last_d;
            len_q   <= len_d;
            gap_q   <= bus.fifo_wr_en;
            pkt_cnt <= cnt_d;
        end
    end

endmodule
